// File: rtl/mycpu_reg_scoreboard.sv
// Register-file scoreboard and issue controller between ID and EX.
// Keeps a small pending-write counter per architectural register, holds back
// instructions with RAW hazards or a saturated destination counter, releases
// entries on writeback and counts stall cycles.
//
// Handshake: issue_valid/issue_ready follow strict valid/ready semantics. An
// instruction transfers on a rising edge where both are high (fire). ID must
// hold the instruction stable while issue_valid=1 and issue_ready=0.
// issue_ready is a pure function of the presented instruction fields, the
// writeback port, flush and the counters; it never looks at issue_valid.
module mycpu_reg_scoreboard #(
  parameter int NREG      = 32,
  parameter int AW        = 5,
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [AW-1:0]   issue_rs,
  input  logic [AW-1:0]   issue_rt,
  input  logic            issue_use_rs,
  input  logic            issue_use_rt,
  input  logic            issue_wen,
  input  logic [AW-1:0]   issue_waddr,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_waddr,
  input  logic            flush,
  output logic [NREG-1:0] busy_vec,
  output logic [15:0]     stall_cnt,
  output logic            wb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Per-register pending-write counters; entry 0 never leaves zero.
  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];

  logic             fire;
  logic             byp_rs;
  logic             byp_rt;
  logic [CNT_W-1:0] eff_rs;
  logic [CNT_W-1:0] eff_rt;
  logic             hz_rs;
  logic             hz_rt;
  logic             hz_dst;
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;
  logic             wb_set_err;

  // Hazard detection: a same-cycle writeback retires one pending write of a
  // source (write-before-read regfile), but the destination-full check uses the
  // raw counter so a retiring write never makes room in the same cycle.
  always_comb begin
    byp_rs = (WB_BYPASS != 0) && wb_valid && (wb_waddr == issue_rs) && (cnt[issue_rs] != '0);
    byp_rt = (WB_BYPASS != 0) && wb_valid && (wb_waddr == issue_rt) && (cnt[issue_rt] != '0);
    eff_rs = byp_rs ? (cnt[issue_rs] - CNT_ONE) : cnt[issue_rs];
    eff_rt = byp_rt ? (cnt[issue_rt] - CNT_ONE) : cnt[issue_rt];
    hz_rs  = issue_use_rs && (eff_rs != '0);
    hz_rt  = issue_use_rt && (eff_rt != '0);
    hz_dst = issue_wen && (issue_waddr != '0) && (cnt[issue_waddr] == CNT_MAX);
    issue_ready = !flush && !hz_rs && !hz_rt && !hz_dst;
  end

  assign fire = issue_valid && issue_ready;

  // Per-register increment on accepted writes, decrement on writeback to a
  // register that actually has a write outstanding.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 1; i < NREG; i++) begin
      inc_vec[i] = fire && issue_wen && (issue_waddr == AW'(i));
      dec_vec[i] = wb_valid && (wb_waddr == AW'(i)) && (cnt[i] != '0);
    end
  end

  // Writeback with nothing outstanding is a pipeline bug; register 0 and
  // flush cycles are exempt.
  assign wb_set_err = wb_valid && !flush && (wb_waddr != '0) && (cnt[wb_waddr] == '0);

  // Counter next state: flush wipes everything, inc and dec together cancel.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt[i] = cnt[i];
      if (flush || i == 0) begin
        cnt_nxt[i] = '0;
      end else if (inc_vec[i] && !dec_vec[i]) begin
        cnt_nxt[i] = cnt[i] + CNT_ONE;
      end else if (!inc_vec[i] && dec_vec[i]) begin
        cnt_nxt[i] = cnt[i] - CNT_ONE;
      end
    end
  end

  // State registers: counters, busy view in step with counters, stall counter
  // and sticky writeback error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        cnt[i] <= '0;
      end
      busy_vec  <= '0;
      stall_cnt <= '0;
      wb_err    <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt[i]      <= cnt_nxt[i];
        busy_vec[i] <= (cnt_nxt[i] != '0);
      end
      if (issue_valid && !issue_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (wb_set_err) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mycpu_reg_scoreboard.sv
// Bench for mycpu_reg_scoreboard: directed scenarios plus random traffic,
// checked against a pending-count model kept as plain integer arrays.
module tb_mycpu_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rs;
  logic [4:0]  issue_rt;
  logic        issue_use_rs;
  logic        issue_use_rt;
  logic        issue_wen;
  logic [4:0]  issue_waddr;
  logic        wb_valid;
  logic [4:0]  wb_waddr;
  logic        flush;
  logic [31:0] busy_vec;
  logic [15:0] stall_cnt;
  logic        wb_err;

  mycpu_reg_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_rs     (issue_rs),
    .issue_rt     (issue_rt),
    .issue_use_rs (issue_use_rs),
    .issue_use_rt (issue_use_rt),
    .issue_wen    (issue_wen),
    .issue_waddr  (issue_waddr),
    .wb_valid     (wb_valid),
    .wb_waddr     (wb_waddr),
    .flush        (flush),
    .busy_vec     (busy_vec),
    .stall_cnt    (stall_cnt),
    .wb_err       (wb_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model + scoreboard ----------------
  int          pend [32];
  int          m_stall;
  logic        m_err;
  int          vectors;
  int          miscompares;
  logic [0:0]  rdy_q [$];
  logic [48:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend[i] = 0;
    m_stall = 0;
    m_err   = 1'b0;
  endtask

  // One clock of stimulus: drive at the falling edge, predict ready for this
  // cycle and the register outputs after the following rising edge.
  task automatic cycle(input logic iv, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic wen,
                       input logic [4:0] wa, input logic wbv, input logic [4:0] wba,
                       input logic fl);
    int          e_rs;
    int          e_rt;
    logic        rdy;
    logic [31:0] busy;
    @(negedge clk);
    issue_valid = iv;  issue_rs = rs;  issue_rt = rt;
    issue_use_rs = urs; issue_use_rt = urt;
    issue_wen = wen;   issue_waddr = wa;
    wb_valid = wbv;    wb_waddr = wba;  flush = fl;
    e_rs = pend[rs] - ((wbv && wba == rs && pend[rs] > 0) ? 1 : 0);
    e_rt = pend[rt] - ((wbv && wba == rt && pend[rt] > 0) ? 1 : 0);
    rdy = !fl && !(urs && e_rs > 0) && !(urt && e_rt > 0) && !(wen && wa != 0 && pend[wa] == 3);
    rdy_q.push_back(rdy);
    if (iv && !rdy && m_stall < 65535) m_stall++;
    if (fl) begin
      for (int i = 0; i < 32; i++) pend[i] = 0;
    end else begin
      if (wbv && wba != 0) begin
        if (pend[wba] > 0) pend[wba]--;
        else m_err = 1'b1;
      end
      if (iv && rdy && wen && wa != 0) pend[wa]++;
    end
    for (int i = 0; i < 32; i++) busy[i] = (pend[i] != 0);
    exp_q.push_back({m_err, 16'(m_stall), busy});
  endtask

  // Monitor: combinational ready sampled mid-low-phase.
  initial begin
    logic [0:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rdy_q.size() > 0) begin
        e = rdy_q.pop_front();
        chk("issue_ready", 64'(issue_ready), 64'(e));
      end
    end
  end

  // Monitor: registered outputs sampled just after the rising edge.
  initial begin
    logic [48:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("regs{err,stall,busy}", 64'({wb_err, stall_cnt, busy_vec}), 64'(e));
      end
    end
  end

  task automatic idle_inputs();
    issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_use_rs = 0; issue_use_rt = 0;
    issue_wen = 0; issue_waddr = 0; wb_valid = 0; wb_waddr = 0; flush = 0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [4:0] wba;
    logic       wbv;
    vectors = 0;
    miscompares = 0;
    model_reset();
    idle_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy_vec), 64'(0));
    chk("reset_stall", 64'(stall_cnt), 64'(0));
    chk("reset_err", 64'(wb_err), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // two writes to r5 in flight, one blocked reader, then async reset
    cycle(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    cycle(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("pre_rst_busy5", 64'(busy_vec[5]), 64'(1));
    #1;
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy_vec), 64'(0));
    chk("async_rst_stall", 64'(stall_cnt), 64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // lw r8, then dependent addu, then writeback bypass
    cycle(1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    cycle(1, 8, 0, 1, 0, 1, 9, 0, 0, 0);
    #2 chk("raw_r8_ready", 64'(issue_ready), 64'(0));
    cycle(1, 8, 0, 1, 0, 1, 9, 1, 8, 0);
    #2 chk("bypass_r8_ready", 64'(issue_ready), 64'(1));
    @(posedge clk);
    #1 chk("busy8_cleared", 64'(busy_vec[8]), 64'(0));

    // r3 counter saturation
    cycle(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    #2 chk("r3_full_ready", 64'(issue_ready), 64'(0));
    cycle(1, 0, 0, 0, 0, 1, 3, 1, 3, 0);
    #2 chk("r3_full_wb_ready", 64'(issue_ready), 64'(0));
    cycle(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    #2 chk("r3_room_ready", 64'(issue_ready), 64'(1));

    // simultaneous fire and writeback on r9 (count 1)
    cycle(1, 0, 0, 0, 0, 1, 9, 1, 9, 0);
    @(posedge clk);
    #1 chk("r9_inc_dec_busy", 64'(busy_vec[9]), 64'(1));
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    @(posedge clk);
    #1 chk("r9_drained", 64'(busy_vec[9]), 64'(0));

    // stray writeback sets sticky error; r0 destination never blocks
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
    @(posedge clk);
    #1 chk("wb_err_set", 64'(wb_err), 64'(1));
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    #2 chk("r0_dest_ready", 64'(issue_ready), 64'(1));
    @(posedge clk);
    #1 chk("busy0_zero", 64'(busy_vec[0]), 64'(0));
    chk("wb_err_sticky", 64'(wb_err), 64'(1));

    // flush clears everything pending
    cycle(1, 3, 0, 1, 0, 0, 0, 0, 0, 1);
    #2 chk("flush_ready", 64'(issue_ready), 64'(0));
    @(posedge clk);
    #1 chk("flush_busy", 64'(busy_vec), 64'(0));

    // random traffic over a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      wbv = 1'b0;
      wba = 5'd0;
      if ($urandom_range(0, 99) < 45) begin
        wba = 5'($urandom_range(0, 7));
        wbv = (pend[wba] > 0) || ($urandom_range(0, 9) == 0);
      end
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), wbv, wba, 1'($urandom_range(0, 49) == 0));
    end

    // fill r3 then hold a blocked instruction until stall_cnt saturates
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 3; n++) cycle(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    for (int n = 0; n < 65600; n++) cycle(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    @(posedge clk);
    #1 chk("stall_saturated", 64'(stall_cnt), 64'(16'hFFFF));
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1 chk("final_flush_busy", 64'(busy_vec), 64'(0));
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2 chk("queues_drained", 64'(rdy_q.size() + exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
